cpu_run_monitor: RTL
====================

// Module: cpu_run_monitor
// PURPOSE
//   Synthesizable run monitor for the single-cycle CPU; replaces ad-hoc bench checks.
//   Watches retire, register-writeback and store traffic from the datapath.
//   Evaluates N_CHECKS programmable register/memory value checks.
//   Detects the end-of-program sentinel and enforces a cycle timeout.
//   Reports done/pass status, a hit cycle per check, and a misaligned-store count.
// PARAMETERS
//   N_CHECKS      2             number of value-check channels (>=1)
//   XLEN          32            datapath width
//   CYC_W         16            cycle counter width; must hold MAX_CYCLES
//   MAX_CYCLES    2000          RUN cycles before TIMEOUT
//   END_SENTINEL  32'h0000006F  end-of-program instruction (jal x0,0)
// PORTS
//   clk           in   1           clock, rising edge
//   reset         in   1           synchronous, active-low
//   start         in   1           arm/re-arm pulse; honoured in IDLE, DONE, TIMEOUT
//   retire_valid  in   1           instruction retires this cycle
//   retire_pc     in   XLEN        PC of retiring instruction
//   retire_instr  in   32          retiring instruction word
//   rf_we         in   1           register-file write enable
//   rf_waddr      in   5           register-file write index
//   rf_wdata      in   XLEN        register-file write data
//   st_en         in   1           data-memory store enable
//   st_addr       in   XLEN        store byte address
//   st_data       in   XLEN        store data
//   cfg_is_mem    in   N_CHECKS    per check: 1 = memory check, 0 = register check
//   cfg_target    in   N_CHECKS*XLEN  register index (bits [4:0]) or byte address
//   cfg_value     in   N_CHECKS*XLEN  expected value
//   state         out  2           0 IDLE, 1 RUN, 2 DONE, 3 TIMEOUT
//   done          out  1           1 in DONE or TIMEOUT
//   pass          out  1           1 only in DONE with all checks hit
//   hit           out  N_CHECKS    sticky per-check hit flags
//   hit_cycle     out  N_CHECKS*CYC_W  value of cycles at first hit
//   cycles        out  CYC_W       RUN cycle count
//   end_pc        out  XLEN        PC at which the sentinel retired
//   misalign_cnt  out  8           misaligned stores seen; saturates at 255
// BEHAVIOUR
//   - reset==0 at an edge: state=IDLE; every output and latched config cleared to 0.
//   - IDLE: start=1 -> RUN at the next edge.
//     On that same edge: cfg_* latched; cycles, hit, hit_cycle, misalign_cnt, end_pc, pass cleared.
//   - RUN: cycles increments by 1 every edge.
//     Event checks use the pre-increment value (first RUN edge sees cycles=0).
//   - RUN: start is ignored. Config ports are ignored after latching.
//   - Register check k: rf_we && rf_waddr==tgt[4:0] && rf_waddr!=0 && rf_wdata==val
//     -> hit[k] set. A check targeting x0 never hits.
//   - Memory check k: st_en && st_addr==tgt && st_addr[1:0]==0 && st_data==val
//     -> hit[k] set.
//   - hit is sticky; later mismatching writes never clear it.
//   - hit_cycle[k] is written only on the first hit of check k.
//   - Misaligned store: st_en && st_addr[1:0]!=0 in RUN -> misalign_cnt+1, saturating at 255.
//   - Sentinel: retire_valid && retire_instr==END_SENTINEL in RUN -> DONE next edge.
//     end_pc = retire_pc.
//     pass = AND of the hit flags including any hit on this same edge.
//   - Timeout: in RUN with cycles==MAX_CYCLES-1 and no sentinel -> TIMEOUT; pass=0.
//   - Sentinel and timeout on the same edge: the sentinel wins (DONE).
//   - DONE/TIMEOUT: all outputs frozen; inputs ignored except start.
//     start=1 re-arms exactly as from IDLE.
//   - Reset asserted mid-RUN: IDLE at that edge; no partial status retained.
//   - Latency: every status update is visible one edge after the triggering input.
// TESTING
//   1. Reg check x6=0x10, then mem check 0x40=0xDEADBEEF; write x6=0x10 at cycle 3.
//      Store 0x40=0xDEADBEEF at cycle 7; sentinel at PC 0x2C, cycle 9
//      -> DONE, pass=1, hit_cycle={7,3}, end_pc=0x2C.
//   2. Same config, store never occurs, sentinel at cycle 9 -> DONE, pass=0, hit=2'b01.
//   3. No sentinel -> TIMEOUT after exactly 2000 RUN cycles, cycles=2000, pass=0.
//   4. Sentinel at cycle 1999 -> DONE, not TIMEOUT.
//      Store hit and sentinel on the same edge -> pass=1.
//   5. Stores to 0x41 and 0x42, then 300 stores to 0x43 -> misalign_cnt saturates at 255.
//      No check hits (a store to 0x41 with the matching value still misses).
//   6. reset=0 for one edge mid-RUN -> state=IDLE, all outputs 0.
//      A start after DONE clears hit and cycles and re-runs.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// Run monitor for the single-cycle CPU: tracks register/memory value checks, misaligned
// stores, the end-of-program sentinel and a RUN-cycle timeout.
module cpu_run_monitor #(
   parameter int          N_CHECKS     = 2,
   parameter int          XLEN         = 32,
   parameter int          CYC_W        = 16,
   parameter int          MAX_CYCLES   = 2000,
   parameter logic [31:0] END_SENTINEL = 32'h0000_006F
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      retire_valid,
   input  logic [XLEN-1:0]           retire_pc,
   input  logic [31:0]               retire_instr,
   input  logic                      rf_we,
   input  logic [4:0]                rf_waddr,
   input  logic [XLEN-1:0]           rf_wdata,
   input  logic                      st_en,
   input  logic [XLEN-1:0]           st_addr,
   input  logic [XLEN-1:0]           st_data,
   input  logic [N_CHECKS-1:0]       cfg_is_mem,
   input  logic [N_CHECKS*XLEN-1:0]  cfg_target,
   input  logic [N_CHECKS*XLEN-1:0]  cfg_value,
   output logic [1:0]                state,
   output logic                      done,
   output logic                      pass,
   output logic [N_CHECKS-1:0]       hit,
   output logic [N_CHECKS*CYC_W-1:0] hit_cycle,
   output logic [CYC_W-1:0]          cycles,
   output logic [XLEN-1:0]           end_pc,
   output logic [7:0]                misalign_cnt
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;
   localparam logic [1:0] S_TIMEOUT = 2'd3;

   logic [1:0]                r_state;
   logic [1:0]                w_next_state;
   logic [N_CHECKS-1:0]       r_cfg_is_mem;
   logic [N_CHECKS*XLEN-1:0]  r_cfg_target;
   logic [N_CHECKS*XLEN-1:0]  r_cfg_value;
   logic [N_CHECKS-1:0]       r_hit;
   logic [N_CHECKS*CYC_W-1:0] r_hit_cycle;
   logic [CYC_W-1:0]          r_cycles;
   logic [XLEN-1:0]           r_end_pc;
   logic [7:0]                r_misalign;
   logic                      r_pass;

   logic [N_CHECKS-1:0]       w_match;
   logic                      w_sentinel;
   logic                      w_timeout;
   logic                      w_misalign;
   logic                      w_arm;
   logic                      w_run;

   assign w_run      = (r_state == S_RUN);
   assign w_arm      = start && !w_run;
   assign w_sentinel = retire_valid && (retire_instr == END_SENTINEL);
   assign w_timeout  = (r_cycles == CYC_W'(MAX_CYCLES - 1));
   assign w_misalign = st_en && (st_addr[1:0] != 2'b00);

   // Per-check comparators against the configuration latched at arm time.
   for (genvar g = 0; g < N_CHECKS; g++) begin : g_chk
      logic [XLEN-1:0] w_tgt;
      logic [XLEN-1:0] w_val;
      logic            w_reg_hit;
      logic            w_mem_hit;
      assign w_tgt     = r_cfg_target[g*XLEN +: XLEN];
      assign w_val     = r_cfg_value[g*XLEN +: XLEN];
      assign w_reg_hit = rf_we && (rf_waddr == w_tgt[4:0]) && (rf_waddr != 5'd0) &&
                         (rf_wdata == w_val);
      assign w_mem_hit = st_en && (st_addr == w_tgt) && (st_addr[1:0] == 2'b00) &&
                         (st_data == w_val);
      assign w_match[g] = r_cfg_is_mem[g] ? w_mem_hit : w_reg_hit;
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_RUN: begin
            if (w_sentinel)     w_next_state = S_DONE;
            else if (w_timeout) w_next_state = S_TIMEOUT;
         end
         default: begin
            if (start) w_next_state = S_RUN;
         end
      endcase
   end

   always_comb begin
      state = r_state;
      done  = (r_state == S_DONE) || (r_state == S_TIMEOUT);
   end

   // Status registers only move in RUN or on an arm; DONE/TIMEOUT hold everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cfg_is_mem <= '0;
         r_cfg_target <= '0;
         r_cfg_value  <= '0;
         r_hit        <= '0;
         r_hit_cycle  <= '0;
         r_cycles     <= '0;
         r_end_pc     <= '0;
         r_misalign   <= '0;
         r_pass       <= 1'b0;
      end else if (w_arm) begin
         r_cfg_is_mem <= cfg_is_mem;
         r_cfg_target <= cfg_target;
         r_cfg_value  <= cfg_value;
         r_hit        <= '0;
         r_hit_cycle  <= '0;
         r_cycles     <= '0;
         r_end_pc     <= '0;
         r_misalign   <= '0;
         r_pass       <= 1'b0;
      end else if (w_run) begin
         r_cycles <= r_cycles + 1'b1;
         r_hit    <= r_hit | w_match;
         for (int k = 0; k < N_CHECKS; k++) begin
            if (w_match[k] && !r_hit[k]) r_hit_cycle[k*CYC_W +: CYC_W] <= r_cycles;
         end
         if (w_misalign && (r_misalign != 8'hFF)) r_misalign <= r_misalign + 8'd1;
         if (w_sentinel) begin
            r_end_pc <= retire_pc;
            r_pass   <= &(r_hit | w_match);
         end else if (w_timeout) begin
            r_pass   <= 1'b0;
         end
      end
   end

   assign pass         = r_pass;
   assign hit          = r_hit;
   assign hit_cycle    = r_hit_cycle;
   assign cycles       = r_cycles;
   assign end_pc       = r_end_pc;
   assign misalign_cnt = r_misalign;

endmodule
